// File: rtl/i2c_slave_transaction_controller.sv
`timescale 1ns/1ps
// I2C slave bus sequencer: decodes START/STOP from synchronized SDA/SCL, acknowledges its address,
// hands received bytes out and shifts read bytes onto the open-drain SDA pad.
module i2c_slave_transaction_controller #(
    parameter logic [6:0] SLAVE_ADDRESS       = 7'h50,
    parameter bit         GENERAL_CALL_ENABLE = 1'b0
) (
    input  logic       control_clock,
    input  logic       reset,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_pull_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_request,
    input  logic [7:0] tx_data,
    output logic       address_match,
    output logic       bus_busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] tx_shift_r, tx_shift_s;
    logic       ack_seen_r, ack_seen_s;
    logic       rw_r, rw_s;
    logic       sda_q_r, scl_q_r;
    logic       sda_pull_low_r, sda_pull_low_s;
    logic [7:0] rx_data_r, rx_data_s;
    logic       rx_valid_r, rx_valid_s;
    logic       tx_request_r, tx_request_s;
    logic       address_match_r, address_match_s;
    logic       bus_busy_r, bus_busy_s;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s, addr_hit_s;
    logic [7:0] shift_in_s;

    // SDA changes that coincide with an SCL edge never qualify as START/STOP (scl_q must already be high)
    assign scl_rise_s = ~scl_q_r & scl_in;
    assign scl_fall_s = scl_q_r & ~scl_in;
    assign start_s    = scl_q_r & scl_in & sda_q_r & ~sda_in;
    assign stop_s     = scl_q_r & scl_in & ~sda_q_r & sda_in;
    assign shift_in_s = {shift_r[6:0], sda_in};
    assign addr_hit_s = (shift_in_s[7:1] == SLAVE_ADDRESS) ||
                        (GENERAL_CALL_ENABLE && (shift_in_s[7:1] == 7'h00) && !shift_in_s[0]);

    assign sda_pull_low  = sda_pull_low_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign tx_request    = tx_request_r;
    assign address_match = address_match_r;
    assign bus_busy      = bus_busy_r;

    // Next-state and next-output decode; bus conditions override every protocol state
    always_comb begin
        state_s         = state_r;
        bit_cnt_s       = bit_cnt_r;
        shift_s         = shift_r;
        tx_shift_s      = tx_shift_r;
        ack_seen_s      = ack_seen_r;
        rw_s            = rw_r;
        sda_pull_low_s  = sda_pull_low_r;
        rx_data_s       = rx_data_r;
        rx_valid_s      = 1'b0;
        tx_request_s    = 1'b0;
        address_match_s = address_match_r;
        bus_busy_s      = bus_busy_r;
        if (start_s) begin
            state_s         = ST_ADDR;
            bit_cnt_s       = 3'd0;
            ack_seen_s      = 1'b0;
            sda_pull_low_s  = 1'b0;
            address_match_s = 1'b0;
            bus_busy_s      = 1'b1;
        end else if (stop_s) begin
            state_s         = ST_IDLE;
            bit_cnt_s       = 3'd0;
            ack_seen_s      = 1'b0;
            sda_pull_low_s  = 1'b0;
            address_match_s = 1'b0;
            bus_busy_s      = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_s   = shift_in_s;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r != 3'd7) begin
                            state_s = state_r;
                        end else if (state_r == ST_WR_DATA) begin
                            rx_data_s  = shift_in_s;
                            rx_valid_s = 1'b1;
                            ack_seen_s = 1'b0;
                            state_s    = ST_WR_ACK;
                        end else if (addr_hit_s) begin
                            rw_s            = shift_in_s[0];
                            ack_seen_s      = 1'b0;
                            address_match_s = 1'b1;
                            state_s         = ST_ADDR_ACK;
                        end else begin
                            state_s = ST_IGNORE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                // First fall asserts the ACK, the ACK clock's rise arms the release on the next fall
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_rise_s) begin
                        ack_seen_s   = 1'b1;
                        tx_request_s = (state_r == ST_ADDR_ACK) && rw_r;
                    end else if (scl_fall_s) begin
                        if (!ack_seen_r) begin
                            sda_pull_low_s = 1'b1;
                        end else if ((state_r == ST_ADDR_ACK) && rw_r) begin
                            sda_pull_low_s = ~tx_data[7];
                            tx_shift_s     = {tx_data[6:0], 1'b0};
                            bit_cnt_s      = 3'd0;
                            state_s        = ST_RD_DATA;
                        end else begin
                            sda_pull_low_s = 1'b0;
                            bit_cnt_s      = 3'd0;
                            state_s        = ST_WR_DATA;
                        end
                    end else begin
                        ack_seen_s = ack_seen_r;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall_s) begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            sda_pull_low_s = 1'b0;
                            ack_seen_s     = 1'b0;
                            state_s        = ST_RD_ACK;
                        end else begin
                            sda_pull_low_s = ~tx_shift_r[7];
                            tx_shift_s     = {tx_shift_r[6:0], 1'b0};
                        end
                    end else begin
                        state_s = ST_RD_DATA;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (!sda_in) begin
                            tx_request_s = 1'b1;
                            ack_seen_s   = 1'b1;
                        end else begin
                            state_s = ST_IGNORE;
                        end
                    end else if (scl_fall_s && ack_seen_r) begin
                        sda_pull_low_s = ~tx_data[7];
                        tx_shift_s     = {tx_data[6:0], 1'b0};
                        bit_cnt_s      = 3'd0;
                        state_s        = ST_RD_DATA;
                    end else begin
                        state_s = ST_RD_ACK;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_pull_low_s = 1'b0;
                end
                default: begin
                    state_s        = ST_IDLE;
                    sda_pull_low_s = 1'b0;
                end
            endcase
        end
    end

    // State, line-history and output registers
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            bit_cnt_r       <= 3'd0;
            shift_r         <= 8'h00;
            tx_shift_r      <= 8'h00;
            ack_seen_r      <= 1'b0;
            rw_r            <= 1'b0;
            sda_q_r         <= 1'b1;
            scl_q_r         <= 1'b1;
            sda_pull_low_r  <= 1'b0;
            rx_data_r       <= 8'h00;
            rx_valid_r      <= 1'b0;
            tx_request_r    <= 1'b0;
            address_match_r <= 1'b0;
            bus_busy_r      <= 1'b0;
        end else begin
            state_r         <= state_s;
            bit_cnt_r       <= bit_cnt_s;
            shift_r         <= shift_s;
            tx_shift_r      <= tx_shift_s;
            ack_seen_r      <= ack_seen_s;
            rw_r            <= rw_s;
            sda_q_r         <= sda_in;
            scl_q_r         <= scl_in;
            sda_pull_low_r  <= sda_pull_low_s;
            rx_data_r       <= rx_data_s;
            rx_valid_r      <= rx_valid_s;
            tx_request_r    <= tx_request_s;
            address_match_r <= address_match_s;
            bus_busy_r      <= bus_busy_s;
        end
    end

endmodule

// File: tb/tb_i2c_slave_transaction_controller.sv
`timescale 1ns/1ps
// Bench for i2c_slave_transaction_controller: a bit-banged I2C master runs directed and random
// transactions while a transaction-level model predicts ACKs, read bits and byte handshakes.
module tb_i2c_slave_transaction_controller;
    localparam logic [6:0] SLAVE = 7'h50;
    localparam bit         GCE   = 1'b0;

    logic       clk = 1'b0;
    logic       reset, msda, mscl;
    logic       sda_in, scl_in;
    logic       sda_pull_low, rx_valid, tx_request, address_match, bus_busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         check_en = 1'b0, exp_pull = 1'b0;
    bit         m_busy = 1'b0, m_match = 1'b0, m_wr = 1'b0, m_rd = 1'b0;
    int         pull_cnt = 0, rx_pulses = 0, tx_req_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] data_buf[4];
    logic [7:0] got_buf[4];

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it
    assign scl_in = mscl;
    assign sda_in = msda & ~sda_pull_low;

    i2c_slave_transaction_controller #(.SLAVE_ADDRESS(SLAVE), .GENERAL_CALL_ENABLE(GCE)) dut (
        .control_clock(clk),
        .reset        (reset),
        .sda_in       (sda_in),
        .scl_in       (scl_in),
        .sda_pull_low (sda_pull_low),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_request   (tx_request),
        .tx_data      (tx_data),
        .address_match(address_match),
        .bus_busy     (bus_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: bus outputs against the model during SCL-high phases, plus byte handshakes
    always @(negedge clk) begin
        if (sda_pull_low) pull_cnt++;
        if (check_en) begin
            check("sda_pull_low", {31'd0, sda_pull_low}, {31'd0, exp_pull});
            check("bus_busy", {31'd0, bus_busy}, {31'd0, m_busy});
            check("address_match", {31'd0, address_match}, {31'd0, m_match});
        end
        if (rx_valid) begin
            rx_pulses++;
            last_rx = rx_data;
            if (rx_exp_q.size() == 0) check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
            else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
        end
        if (tx_request) begin
            tx_req_cnt++;
            if (tx_q.size() == 0) tx_data = 8'hFF;
            else tx_data = tx_q.pop_front();
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual timeout, required finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL pulse; entered and left with SCL low. simul moves SDA in the same cycle SCL rises.
    task automatic clk_bit(input bit mbit, input bit simul, input bit epull, output bit seen);
        wait_cyc(2);
        if (simul) begin
            msda = ~mbit;
            wait_cyc(2);
            msda = mbit;
            mscl = 1'b1;
        end else begin
            msda = mbit;
            wait_cyc(2);
            mscl = 1'b1;
        end
        wait_cyc(1);
        exp_pull = epull;
        check_en = 1'b1;
        wait_cyc(3);
        seen = sda_in;
        check_en = 1'b0;
        mscl = 1'b0;
    endtask

    task automatic i2c_start();
        if (!mscl) begin
            msda = 1'b1;
            wait_cyc(2);
            mscl = 1'b1;
        end
        wait_cyc(2);
        msda = 1'b0;
        wait_cyc(2);
        m_busy = 1'b1; m_match = 1'b0; m_wr = 1'b0; m_rd = 1'b0;
        check("start_busy", {31'd0, bus_busy}, 32'd1);
        check("start_match", {31'd0, address_match}, 32'd0);
        mscl = 1'b0;
        wait_cyc(1);
    endtask

    task automatic i2c_stop();
        msda = 1'b0;
        wait_cyc(2);
        mscl = 1'b1;
        wait_cyc(2);
        check("stop_released", {31'd0, sda_pull_low}, 32'd0);
        msda = 1'b1;
        wait_cyc(2);
        m_busy = 1'b0; m_match = 1'b0; m_wr = 1'b0; m_rd = 1'b0;
        check("stop_busy", {31'd0, bus_busy}, 32'd0);
        check("stop_match", {31'd0, address_match}, 32'd0);
    endtask

    task automatic send_addr(input logic [6:0] a, input bit rw);
        bit         hit, s;
        logic [7:0] b;
        b   = {a, rw};
        hit = (a == SLAVE) || (GCE && (a == 7'h00) && !rw);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) m_match = hit;
            clk_bit(b[i], 1'b0, 1'b0, s);
        end
        clk_bit(1'b1, 1'b0, hit, s);
        check("addr_ack", {31'd0, s}, {31'd0, !hit});
        m_wr = hit && !rw;
        m_rd = hit && rw;
    endtask

    task automatic send_wbyte(input logic [7:0] b, input int smode);
        bit s, sim;
        if (m_wr) rx_exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            sim = (smode == 1) || ((smode == 2) && ($urandom_range(0, 1) == 1));
            clk_bit(b[i], sim, 1'b0, s);
        end
        clk_bit(1'b1, 1'b0, m_wr, s);
        check("wr_ack", {31'd0, s}, {31'd0, !m_wr});
    endtask

    task automatic read_byte(input logic [7:0] b, input bit nack, output logic [7:0] got);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, m_rd && !b[i], s);
            got[i] = s;
        end
        clk_bit(nack, 1'b0, 1'b0, s);
        if (nack) m_rd = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input int n, input int smode);
        i2c_start();
        send_addr(a, 1'b0);
        for (int k = 0; k < n; k++) send_wbyte(data_buf[k], smode);
        i2c_stop();
        check("rx_all_delivered", rx_exp_q.size(), 32'd0);
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        bit         hit;
        int         r0;
        logic [7:0] g;
        tx_q.delete();
        for (int k = 0; k < n; k++) tx_q.push_back(data_buf[k]);
        r0 = tx_req_cnt;
        i2c_start();
        send_addr(a, 1'b1);
        hit = m_rd;
        for (int k = 0; k < n; k++) begin
            read_byte(data_buf[k], k == n - 1, g);
            got_buf[k] = g;
            if (hit) check("rd_byte", {24'd0, g}, {24'd0, data_buf[k]});
        end
        i2c_stop();
        check("rd_tx_requests", tx_req_cnt - r0, hit ? n : 0);
    endtask

    initial begin
        int         rx0, p0, r0, n, sel;
        bit         s;
        logic [6:0] a;
        logic [7:0] g;
        logic [7:0] pat;

        reset = 1'b1; msda = 1'b1; mscl = 1'b1;
        wait_cyc(3);
        check("rst_sda_pull_low", {31'd0, sda_pull_low}, 32'd0);
        check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b0;
        wait_cyc(3);

        // Write 0xA5 to the slave
        data_buf[0] = 8'hA5;
        rx0 = rx_pulses;
        do_write(SLAVE, 1, 0);
        check("t1_rx_pulses", rx_pulses - rx0, 32'd1);
        check("t1_rx_data", {24'd0, last_rx}, 32'h0000_00A5);

        // Foreign address 0x51: never acknowledged, nothing received
        data_buf[0] = 8'h3A;
        rx0 = rx_pulses; p0 = pull_cnt;
        do_write(7'h51, 1, 0);
        check("t2_no_pull", pull_cnt - p0, 32'd0);
        check("t2_rx_pulses", rx_pulses - rx0, 32'd0);

        // Read 0x3C then 0xC3, master ACK then NACK
        data_buf[0] = 8'h3C; data_buf[1] = 8'hC3;
        r0 = tx_req_cnt;
        do_read(SLAVE, 2);
        check("t3_byte0", {24'd0, got_buf[0]}, 32'h0000_003C);
        check("t3_byte1", {24'd0, got_buf[1]}, 32'h0000_00C3);
        check("t3_tx_requests", tx_req_cnt - r0, 32'd2);

        // Repeated START four bits into a write byte, then a clean read
        tx_q.delete(); tx_q.push_back(8'h96);
        r0 = tx_req_cnt; rx0 = rx_pulses;
        i2c_start();
        send_addr(SLAVE, 1'b0);
        pat = 8'hB0;
        for (int i = 7; i >= 4; i--) clk_bit(pat[i], 1'b0, 1'b0, s);
        i2c_start();
        send_addr(SLAVE, 1'b1);
        read_byte(8'h96, 1'b1, g);
        i2c_stop();
        check("t4_rd_byte", {24'd0, g}, 32'h0000_0096);
        check("t4_tx_requests", tx_req_cnt - r0, 32'd1);
        check("t4_rx_pulses", rx_pulses - rx0, 32'd0);

        // Every data bit moves SDA in the same cycle SCL rises
        data_buf[0] = 8'h5A;
        do_write(SLAVE, 1, 1);
        check("t6_rx_data", {24'd0, last_rx}, 32'h0000_005A);

        // Reset while the address ACK is being driven
        i2c_start();
        pat = {SLAVE, 1'b0};
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) m_match = 1'b1;
            clk_bit(pat[i], 1'b0, 1'b0, s);
        end
        wait_cyc(2);
        check("t5_ack_driven", {31'd0, sda_pull_low}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_sda", {31'd0, sda_pull_low}, 32'd0);
        check("t5_rst_match", {31'd0, address_match}, 32'd0);
        check("t5_rst_busy", {31'd0, bus_busy}, 32'd0);
        check("t5_rst_rx", {23'd0, rx_valid, rx_data}, 32'd0);
        check("t5_rst_txreq", {31'd0, tx_request}, 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        m_busy = 1'b0; m_match = 1'b0; m_wr = 1'b0; m_rd = 1'b0;
        pat = {SLAVE, 1'b0};
        for (int i = 7; i >= 0; i--) clk_bit(pat[i], 1'b0, 1'b0, s);
        clk_bit(1'b1, 1'b0, 1'b0, s);
        msda = 1'b1;
        wait_cyc(2);
        mscl = 1'b1;
        wait_cyc(2);

        // Random transactions against the model
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 3);
            if (sel <= 1) a = SLAVE;
            else if (sel == 2) a = 7'($urandom_range(0, 127));
            else a = 7'h00;
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) data_buf[k] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) do_read(a, n);
            else do_write(a, n, 2);
            wait_cyc(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
